// File: rtl/classifier_host_ctrl_pkg.sv
// Shared types, constants and the one-hot class encoder for the classifier host controller.
package classifier_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;
    localparam logic [IDX_W-1:0] IDX_ERR = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_PUSH  = 2'd3
    } state_t;

    // Returns {err, idx}: idx of the single set bit, or {1, IDX_ERR} when zero or several bits are set.
    function automatic logic [IDX_W:0] onehot_to_idx(input logic [0:NUM_CLASSES-1] v);
        logic [IDX_W-1:0] idx;
        int               hits;
        idx  = IDX_ERR;
        hits = 0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (v[k]) begin
                hits++;
                idx = IDX_W'(k);
            end
        end
        if (hits == 1) return {1'b0, idx};
        return {1'b1, IDX_ERR};
    endfunction

endpackage

// File: rtl/classifier_host_ctrl_if.sv
// Host-side and TOP-side signals of the classifier host controller.
// master = the controller itself, slave = the host plus TOP environment.
interface classifier_host_ctrl_if #(parameter int RUN_W = 8);
    import classifier_pkg::*;

    logic                      go;
    logic [RUN_W-1:0]          num_runs;
    logic                      busy;
    logic                      start;
    logic                      done;
    logic [0:NUM_CLASSES-1]    out_vec;
    logic                      res_valid;
    logic                      res_ready;
    logic [IDX_W-1:0]          res_idx;
    logic                      res_err;
    logic [7:0]                err_count;

    modport master (
        input  go, num_runs, done, out_vec, res_ready,
        output busy, start, res_valid, res_idx, res_err, err_count
    );

    modport slave (
        output go, num_runs, done, out_vec, res_ready,
        input  busy, start, res_valid, res_idx, res_err, err_count
    );

endinterface

// File: rtl/classifier_host_ctrl_result_fifo.sv
// Show-ahead result FIFO with extra-MSB pointers; a pop frees room for a same-cycle push.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/classifier_host_ctrl.sv
// Run sequencer for TOP: issues 2-cycle start pulses, waits for done (with timeout),
// encodes the one-hot result and queues {idx, err} in the result FIFO.
module classifier_host_ctrl
    import classifier_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024,
    parameter int RUN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    classifier_host_ctrl_if.master  bus
);
    localparam int TMO_W = $clog2(TIMEOUT);

    state_t                 state_q, state_d;
    logic                   start_cnt_q, start_cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [RUN_W-1:0]       runs_q, runs_d;
    logic [0:NUM_CLASSES-1] vec_q, vec_d;
    logic                   tflag_q, tflag_d;
    logic                   busy_q, busy_d;
    logic                   start_q, start_d;
    logic [7:0]             errc_q, errc_d;

    logic                   push;
    logic [IDX_W:0]         enc;
    logic                   entry_err;
    logic [IDX_W-1:0]       entry_idx;
    logic [IDX_W:0]         fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign enc       = onehot_to_idx(vec_q);
    assign entry_err = tflag_q | enc[IDX_W];
    assign entry_idx = entry_err ? IDX_ERR : enc[IDX_W-1:0];

    result_fifo #(.DEPTH(FIFO_DEPTH), .W(IDX_W + 1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({entry_idx, entry_err}),
        .pop   (bus.res_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.busy      = busy_q;
    assign bus.start     = start_q;
    assign bus.res_valid = !fifo_empty;
    assign bus.res_idx   = fifo_dout[IDX_W:1];
    assign bus.res_err   = fifo_dout[0];
    assign bus.err_count = errc_q;

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_cnt_q <= 1'b0;
            tmo_q       <= '0;
            runs_q      <= '0;
            vec_q       <= '0;
            tflag_q     <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            errc_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            tmo_q       <= tmo_d;
            runs_q      <= runs_d;
            vec_q       <= vec_d;
            tflag_q     <= tflag_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            errc_q      <= errc_d;
        end
    end

    // Next-state logic; start_d is high exactly while the next state is START.
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        tmo_d       = tmo_q;
        runs_d      = runs_q;
        vec_d       = vec_q;
        tflag_d     = tflag_q;
        busy_d      = busy_q;
        start_d     = 1'b0;
        errc_d      = errc_q;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.go && bus.num_runs != '0) begin
                    runs_d      = RUN_W'(bus.num_runs);
                    busy_d      = 1'b1;
                    start_d     = 1'b1;
                    start_cnt_d = 1'b0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (!start_cnt_q) begin
                    start_cnt_d = 1'b1;
                    start_d     = 1'b1;
                end else begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // tmo_q == 0 is TOP's mandatory idle cycle: done is not looked at yet.
                if (tmo_q != '0 && bus.done) begin
                    vec_d   = bus.out_vec;
                    tflag_d = 1'b0;
                    state_d = S_PUSH;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    tflag_d = 1'b1;
                    state_d = S_PUSH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_PUSH: begin
                // A full FIFO still has room when the host pops in the same cycle.
                if (!fifo_full || bus.res_ready) begin
                    push   = 1'b1;
                    runs_d = runs_q - 1'b1;
                    if (entry_err && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
                    if (runs_q > RUN_W'(1)) begin
                        start_d     = 1'b1;
                        start_cnt_d = 1'b0;
                        state_d     = S_START;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_classifier_host_ctrl.sv
// Scoreboard bench for classifier_host_ctrl with a behavioural TOP model.
module tb_classifier_host_ctrl;
    import classifier_pkg::*;

    localparam int TIMEOUT = 1024;

    typedef struct {
        int          dly;
        logic [0:9]  vec;
    } run_t;

    typedef struct {
        logic [3:0] idx;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    classifier_host_ctrl_if #(.RUN_W(8)) bus();

    classifier_host_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .RUN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    run_t cfg_q[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rises   = 0;
    int   falls   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [0:9] cls(input int k);
        logic [0:9] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic add_run(input int dly, input logic [0:9] vec, input logic [3:0] idx, input logic err);
        run_t r;
        exp_t e;
        r.dly = dly;
        r.vec = vec;
        e.idx = idx;
        e.err = err;
        cfg_q.push_back(r);
        sb_q.push_back(e);
    endtask

    task automatic go_batch(input int n);
        @(posedge clk); #1;
        bus.go       = 1'b1;
        bus.num_runs = 8'(n);
        @(posedge clk); #1;
        bus.go       = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.res_valid && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_val(tag, ok, 1);
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // TOP model: after start falls, pulse done with the configured vector dly cycles later.
    initial begin
        run_t cur;
        int   cnt;
        logic active;
        logic prev;
        bus.done    = 1'b0;
        bus.out_vec = '0;
        active      = 1'b0;
        prev        = 1'b0;
        cnt         = 0;
        forever begin
            @(posedge clk); #1;
            bus.done = 1'b0;
            if (!rst_n) begin
                active = 1'b0;
                prev   = 1'b0;
            end else begin
                if (active) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.done    = 1'b1;
                        bus.out_vec = cur.vec;
                        active      = 1'b0;
                    end
                end
                if (prev && !bus.start && cfg_q.size() > 0) begin
                    cur = cfg_q.pop_front();
                    if (cur.dly > 0) begin
                        cnt    = cur.dly;
                        active = 1'b1;
                    end
                end
                prev = bus.start;
            end
        end
    end

    // Output monitor: start pulse width/count and scoreboard pops.
    initial begin
        logic mon_prev;
        int   width;
        exp_t e;
        mon_prev = 1'b0;
        width    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev = 1'b0;
                width    = 0;
            end else begin
                if (bus.start) width++;
                if (bus.start && !mon_prev) rises++;
                if (!bus.start && mon_prev) begin
                    falls++;
                    check_val("start_width", width, 2);
                    width = 0;
                end
                mon_prev = bus.start;
                if (bus.res_valid && bus.res_ready) begin
                    if (sb_q.size() == 0) begin
                        check_val("sb_unexpected_pop", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        check_val("pop_idx", bus.res_idx, e.idx);
                        check_val("pop_err", bus.res_err, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, v, e, base;
        rst_n        = 1'b0;
        bus.go       = 1'b0;
        bus.num_runs = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_start", bus.start, 0);
        check_val("rst_valid", bus.res_valid, 0);
        check_val("rst_idx", bus.res_idx, 0);
        check_val("rst_err", bus.res_err, 0);
        check_val("rst_errcnt", bus.err_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single run, class 3, latency checks
        add_run(5, cls(3), 4'd3, 1'b0);
        go_batch(1);
        @(negedge clk);
        check_val("go2start", bus.start, 1);
        check_val("busy_on", bus.busy, 1);
        c = -100;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.done) begin c = cyc; break; end
        end
        v = -1000;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin v = cyc; break; end
        end
        check_val("lat_done2valid", v - c, 2);
        check_val("t1_idx", bus.res_idx, 3);
        check_val("t1_err", bus.res_err, 0);
        check_val("t1_busy_off", bus.busy, 0);
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        wait_idle("t1_idle", 50);

        // num_runs = 0 is not a batch
        go_batch(0);
        @(negedge clk);
        check_val("zero_busy", bus.busy, 0);
        @(negedge clk);
        check_val("zero_start", bus.start, 0);

        // three runs; a second go while busy must be ignored
        base = rises;
        add_run(3, cls(0), 4'd0, 1'b0);
        add_run(7, cls(9), 4'd9, 1'b0);
        add_run(2, cls(5), 4'd5, 1'b0);
        go_batch(3);
        repeat (3) @(negedge clk);
        go_batch(5);
        wait_idle("t2_idle", 200);
        check_val("t2_starts", rises - base, 3);
        check_val("t2_errcnt", bus.err_count, 0);

        // malformed vectors
        add_run(3, 10'b1000000001, 4'hF, 1'b1);
        add_run(5, 10'b0000000000, 4'hF, 1'b1);
        go_batch(2);
        wait_idle("t3_idle", 200);
        check_val("t3_errcnt", bus.err_count, 2);

        // timeout on the first run, normal second run
        add_run(-1, cls(4), 4'hF, 1'b1);
        add_run(4, cls(7), 4'd7, 1'b0);
        go_batch(2);
        e = -100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.start) begin e = cyc; break; end
        end
        v = -1000;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin v = cyc; break; end
        end
        check_val("tmo_latency", v - e, TIMEOUT + 1);
        wait_idle("t4_idle", 200);
        check_val("t4_errcnt", bus.err_count, 3);

        // FIFO fills, controller stalls in PUSH, then drains
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        add_run(2, cls(1), 4'd1, 1'b0);
        add_run(2, cls(2), 4'd2, 1'b0);
        add_run(2, cls(3), 4'd3, 1'b0);
        add_run(2, cls(4), 4'd4, 1'b0);
        add_run(2, cls(6), 4'd6, 1'b0);
        add_run(2, cls(8), 4'd8, 1'b0);
        go_batch(6);
        repeat (120) @(negedge clk);
        check_val("stall_busy", bus.busy, 1);
        check_val("stall_start", bus.start, 0);
        check_val("stall_head", bus.res_idx, 1);
        check_val("stall_cfg_left", cfg_q.size(), 1);
        check_val("stall_sb", sb_q.size(), 6);
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        wait_idle("t5_idle", 200);

        // asynchronous reset in the WAIT of run 2 of 4
        base = falls;
        add_run(10, cls(1), 4'd1, 1'b0);
        add_run(10, cls(2), 4'd2, 1'b0);
        add_run(10, cls(3), 4'd3, 1'b0);
        add_run(10, cls(4), 4'd4, 1'b0);
        go_batch(4);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (falls == base + 2) break;
        end
        repeat (3) @(negedge clk);
        check_val("pre_rst_busy", bus.busy, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_start", bus.start, 0);
        check_val("mid_rst_valid", bus.res_valid, 0);
        check_val("mid_rst_busy", bus.busy, 0);
        check_val("mid_rst_errcnt", bus.err_count, 0);
        sb_q.delete();
        cfg_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_run(3, cls(2), 4'd2, 1'b0);
        go_batch(1);
        wait_idle("t6_idle", 100);
        check_val("t6_errcnt", bus.err_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
